spi_master_arbiter: RTL and testbench

- Shares one spi_Master instance among NREQ requester ports, with round-robin arbitration.
- Holds a per-requester configuration register set: packet size, chip-select address and frequency divider.
- Per transaction: pushes the granted requester's configuration into the master, then issues the message, then routes the master's response back to that requester.
- Sits between on-chip clients (ADC, DSP, loopback) and the SPI master's val/rdy interfaces.

---
 rtl/spi_master_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter sharing one SPI master among nreq requesters
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN (response-stall timeout, sticky err_timeout).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_val/req_rdy/req_msg    per-requester message input (val/rdy)
//   resp_val/resp_rdy          per-requester response handshake
//   resp_msg                   shared response data, qualified by resp_val
//   cfg_val/cfg_rdy/cfg_id     configuration write port and target requester
//   cfg_packet_size/cs_addr/freq  configuration fields
//   spi_recv_*                 message to the SPI master
//   spi_send_*                 response from the SPI master
//   spi_packet_size_*          master packet-size load
//   spi_cs_addr_*              master chip-select load
//   spi_freq_*                 master frequency load
//   err_timeout                sticky response-timeout flag
module spi_master_arbiter #(
  parameter int nbits    = 34,
  parameter int ncs      = 1,
  parameter int nreq     = 2,
  parameter int logBitsN = $clog2(nbits) + 1,
  parameter int logCSN   = (ncs > 1) ? $clog2(ncs) : 1,
  parameter int logReqN  = (nreq > 1) ? $clog2(nreq) : 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [nreq-1:0]            req_val,
  output logic [nreq-1:0]            req_rdy,
  input  logic [nreq-1:0][nbits-1:0] req_msg,
  output logic [nreq-1:0]            resp_val,
  input  logic [nreq-1:0]            resp_rdy,
  output logic [nbits-1:0]           resp_msg,
  input  logic                       cfg_val,
  output logic                       cfg_rdy,
  input  logic [logReqN-1:0]         cfg_id,
  input  logic [logBitsN-1:0]        cfg_packet_size,
  input  logic [logCSN-1:0]          cfg_cs_addr,
  input  logic [2:0]                 cfg_freq,
  output logic                       spi_recv_val,
  input  logic                       spi_recv_rdy,
  output logic [nbits-1:0]           spi_recv_msg,
  input  logic                       spi_send_val,
  output logic                       spi_send_rdy,
  input  logic [nbits-1:0]           spi_send_msg,
  output logic                       spi_packet_size_val,
  input  logic                       spi_packet_size_rdy,
  output logic [logBitsN-1:0]        spi_packet_size_msg,
  output logic                       spi_cs_addr_val,
  input  logic                       spi_cs_addr_rdy,
  output logic [logCSN-1:0]          spi_cs_addr_msg,
  output logic                       spi_freq_val,
  input  logic                       spi_freq_rdy,
  output logic [2:0]                 spi_freq_msg,
  output logic                       err_timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONFIG = 2'd1;
  localparam logic [1:0] XFER   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]          state;
  logic [logReqN-1:0]  grant;
  logic [logReqN-1:0]  rr_ptr;
  logic [logBitsN-1:0] ps_q [nreq];
  logic [logCSN-1:0]   cs_q [nreq];
  logic [2:0]          fq_q [nreq];

  logic                any_req;
  logic [logReqN-1:0]  pick;
  logic [logReqN-1:0]  cand;
  logic [logReqN-1:0]  next_ptr;
  logic                cfg_id_ok;
  logic                cfg_loaded;
  logic                timeout_hit;

  // Only a non-power-of-two nreq can present an out-of-range id.
  if ((1 << logReqN) > nreq) begin : g_id_check
    assign cfg_id_ok = (cfg_id < logReqN'(nreq));
  end else begin : g_id_all
    assign cfg_id_ok = 1'b1;
  end

  // The three config rdys move together on the master; requiring all of
  // them costs nothing and keeps us safe against a master that splits them.
  assign cfg_loaded = spi_packet_size_rdy && spi_cs_addr_rdy && spi_freq_rdy;
  assign next_ptr   = logReqN'((int'(grant) + 1) % nreq);

  // Round-robin pick: scan downward so the last hit is the nearest index
  // at or after rr_ptr.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      cand = logReqN'((int'(rr_ptr) + i) % nreq);
      if (req_val[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNTW-1:0] stall_cnt;
  logic            stalled;
  logic            err_q;

  assign stalled     = (state == RESP) && spi_send_val && !resp_rdy[grant];
  // Fires on the cycle after TIMEOUT stalled cycles have been counted.
  assign timeout_hit = stalled && (stall_cnt == CNTW'(TIMEOUT));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state != RESP) begin
        stall_cnt <= '0;
      end else if (stalled && !timeout_hit) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      cfg_rdy <= 1'b0;
      for (int i = 0; i < nreq; i++) begin
        ps_q[i] <= logBitsN'(nbits);
        cs_q[i] <= '0;
        fq_q[i] <= '0;
      end
    end else begin
      cfg_rdy <= 1'b1;
      if (cfg_val && cfg_id_ok) begin
        ps_q[cfg_id] <= cfg_packet_size;
        cs_q[cfg_id] <= cfg_cs_addr;
        fq_q[cfg_id] <= cfg_freq;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= CONFIG;
          end
        end
        CONFIG: begin
          if (cfg_loaded) begin
            state <= XFER;
          end
        end
        XFER: begin
          // A withdrawn request abandons the grant without advancing rr_ptr.
          if (!req_val[grant]) begin
            state <= IDLE;
          end else if (spi_recv_rdy) begin
            state <= RESP;
          end
        end
        RESP: begin
          if ((spi_send_val && resp_rdy[grant]) || timeout_hit) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_rdy             = '0;
    resp_val            = '0;
    resp_msg            = spi_send_msg;
    spi_recv_val        = 1'b0;
    spi_recv_msg        = req_msg[grant];
    spi_send_rdy        = 1'b0;
    spi_packet_size_val = 1'b0;
    spi_cs_addr_val     = 1'b0;
    spi_freq_val        = 1'b0;
    spi_packet_size_msg = ps_q[grant];
    spi_cs_addr_msg     = cs_q[grant];
    spi_freq_msg        = fq_q[grant];
    case (state)
      CONFIG: begin
        spi_packet_size_val = 1'b1;
        spi_cs_addr_val     = 1'b1;
        spi_freq_val        = 1'b1;
      end
      XFER: begin
        spi_recv_val   = req_val[grant];
        req_rdy[grant] = spi_recv_rdy;
      end
      RESP: begin
        // On timeout the response is drained from the master and dropped.
        resp_val[grant] = spi_send_val && !timeout_hit;
        spi_send_rdy    = resp_rdy[grant] || timeout_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - randomized self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

  localparam int NBITS = 34;
  localparam int NREQ  = 2;
  localparam int LOGB  = $clog2(NBITS) + 1;
  localparam int LOGCS = 1;
  localparam int LOGR  = 1;

  logic                       clk;
  logic                       reset;
  logic [NREQ-1:0]            req_val;
  logic [NREQ-1:0]            req_rdy;
  logic [NREQ-1:0][NBITS-1:0] req_msg;
  logic [NREQ-1:0]            resp_val;
  logic [NREQ-1:0]            resp_rdy;
  logic [NBITS-1:0]           resp_msg;
  logic                       cfg_val;
  logic                       cfg_rdy;
  logic [LOGR-1:0]            cfg_id;
  logic [LOGB-1:0]            cfg_packet_size;
  logic [LOGCS-1:0]           cfg_cs_addr;
  logic [2:0]                 cfg_freq;
  logic                       spi_recv_val, spi_recv_rdy;
  logic [NBITS-1:0]           spi_recv_msg;
  logic                       spi_send_val, spi_send_rdy;
  logic [NBITS-1:0]           spi_send_msg;
  logic                       spi_packet_size_val, spi_packet_size_rdy;
  logic [LOGB-1:0]            spi_packet_size_msg;
  logic                       spi_cs_addr_val, spi_cs_addr_rdy;
  logic [LOGCS-1:0]           spi_cs_addr_msg;
  logic                       spi_freq_val, spi_freq_rdy;
  logic [2:0]                 spi_freq_msg;
  logic                       err_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: per-requester config and the round-robin pointer.
  int m_ps [NREQ];
  int m_cs [NREQ];
  int m_fq [NREQ];
  int m_rr;

  spi_master_arbiter #(.nbits(NBITS), .ncs(1), .nreq(NREQ), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_id(cfg_id),
    .cfg_packet_size(cfg_packet_size), .cfg_cs_addr(cfg_cs_addr), .cfg_freq(cfg_freq),
    .spi_recv_val(spi_recv_val), .spi_recv_rdy(spi_recv_rdy), .spi_recv_msg(spi_recv_msg),
    .spi_send_val(spi_send_val), .spi_send_rdy(spi_send_rdy), .spi_send_msg(spi_send_msg),
    .spi_packet_size_val(spi_packet_size_val), .spi_packet_size_rdy(spi_packet_size_rdy),
    .spi_packet_size_msg(spi_packet_size_msg),
    .spi_cs_addr_val(spi_cs_addr_val), .spi_cs_addr_rdy(spi_cs_addr_rdy),
    .spi_cs_addr_msg(spi_cs_addr_msg),
    .spi_freq_val(spi_freq_val), .spi_freq_rdy(spi_freq_rdy), .spi_freq_msg(spi_freq_msg),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_ps[i] = NBITS;
      m_cs[i] = 0;
      m_fq[i] = 0;
    end
    m_rr = 0;
  endfunction

  // Nearest valid requester at or after the pointer, with wrap.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NBITS-1:0] rand_msg();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NBITS-1:0];
  endfunction

  task automatic cfg_write(input int id, input int ps, input int cs, input int fq);
    cfg_val = 1'b1;
    cfg_id = LOGR'(id);
    cfg_packet_size = LOGB'(ps);
    cfg_cs_addr = LOGCS'(cs);
    cfg_freq = 3'(fq);
    #1;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_rdy: got %b want 1", cfg_rdy);
    end
    @(negedge clk);
    cfg_val = 1'b0;
    if (id < NREQ) begin
      m_ps[id] = ps;
      m_cs[id] = cs;
      m_fq[id] = fq;
    end
  endtask

  // One full transaction starting from IDLE at a negedge; ends at a negedge in IDLE.
  task automatic run_txn(input logic [NREQ-1:0] vals, input logic [NBITS-1:0] msg0,
                         input logic [NBITS-1:0] msg1, input logic [NBITS-1:0] rsp,
                         input int cfg_dly, input int recv_dly, input int stall);
    int g;
    logic [NREQ-1:0] oh;
    logic [NBITS-1:0] exp_msg;
    g = model_pick(vals);
    oh = NREQ'(1) << g;
    exp_msg = (g == 0) ? msg0 : msg1;
    req_val = vals;
    req_msg[0] = msg0;
    req_msg[1] = msg1;
    @(negedge clk);
    for (int c = 0; c <= cfg_dly; c++) begin
      {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = (c == cfg_dly) ? 3'b111 : 3'b000;
      #1;
      checks++;
      if ({spi_packet_size_val, spi_cs_addr_val, spi_freq_val, spi_recv_val} !== 4'b1110) begin
        errors++;
        $display("FAIL config_vals: got %b want 1110", {spi_packet_size_val, spi_cs_addr_val, spi_freq_val, spi_recv_val});
      end
      checks++;
      if (int'(spi_packet_size_msg) != m_ps[g] || int'(spi_cs_addr_msg) != m_cs[g] || int'(spi_freq_msg) != m_fq[g]) begin
        errors++;
        $display("FAIL config_msgs req%0d: got %0d/%0d/%0d want %0d/%0d/%0d", g,
                 spi_packet_size_msg, spi_cs_addr_msg, spi_freq_msg, m_ps[g], m_cs[g], m_fq[g]);
      end
      @(negedge clk);
    end
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b000;
    for (int c = 0; c <= recv_dly; c++) begin
      spi_recv_rdy = (c == recv_dly);
      #1;
      checks++;
      if (spi_recv_val !== 1'b1 || spi_recv_msg !== exp_msg) begin
        errors++;
        $display("FAIL xfer_msg req%0d: got val=%b msg=%h want val=1 msg=%h", g, spi_recv_val, spi_recv_msg, exp_msg);
      end
      checks++;
      if (req_rdy !== (spi_recv_rdy ? oh : '0) || spi_packet_size_val !== 1'b0) begin
        errors++;
        $display("FAIL xfer_rdy: got req_rdy=%b cfgval=%b want req_rdy=%b cfgval=0", req_rdy, spi_packet_size_val, spi_recv_rdy ? oh : '0);
      end
      @(negedge clk);
    end
    spi_recv_rdy = 1'b0;
    spi_send_val = 1'b1;
    spi_send_msg = rsp;
    for (int c = 0; c <= stall; c++) begin
      resp_rdy = ((c == stall) ? oh : '0) | (NREQ'($urandom()) & ~oh);
      #1;
      checks++;
      if (resp_val !== oh || resp_msg !== rsp) begin
        errors++;
        $display("FAIL resp_route: got val=%b msg=%h want val=%b msg=%h", resp_val, resp_msg, oh, rsp);
      end
      checks++;
      if (spi_send_rdy !== (c == stall) || spi_recv_val !== 1'b0 || req_rdy !== '0) begin
        errors++;
        $display("FAIL resp_handshake cyc%0d: got send_rdy=%b recv_val=%b req_rdy=%b want %b/0/00",
                 c, spi_send_rdy, spi_recv_val, req_rdy, c == stall);
      end
      @(negedge clk);
    end
    spi_send_val = 1'b0;
    resp_rdy = '0;
    req_val = '0;
    m_rr = (g + 1) % NREQ;
    #1;
    checks++;
    if ({req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val} !== '0) begin
      errors++;
      $display("FAIL post_txn_idle: got %b want 0", {req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val, spi_cs_addr_val,
         spi_freq_val, cfg_rdy, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {req_rdy, resp_val, spi_recv_val, spi_send_rdy,
               spi_packet_size_val, spi_cs_addr_val, spi_freq_val, cfg_rdy, err_timeout});
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_rdy: got %b want 1", cfg_rdy);
    end
  endtask

  task automatic test_config_ok;
    cfg_write(0, NBITS, 0, 0);
    run_txn(2'b01, 34'h2_AAAA_5555, rand_msg(), rand_msg(), 0, 0, 0);
  endtask

  task automatic test_round_robin;
    for (int t = 0; t < 4; t++)
      run_txn(2'b11, rand_msg(), rand_msg(), rand_msg(), 0, $urandom_range(0, 1), $urandom_range(0, 2));
  endtask

  task automatic test_per_req_config;
    cfg_write(1, 8, 0, 3);
    run_txn(2'b10, rand_msg(), rand_msg(), rand_msg(), 1, 0, 0);
    run_txn(2'b01, rand_msg(), rand_msg(), rand_msg(), 0, 1, 0);
  endtask

  task automatic test_backpressure;
    run_txn(2'b10, rand_msg(), rand_msg(), rand_msg(), 0, 0, 20);
  endtask

  task automatic test_xfer_drop;
    int g;
    req_val = 2'b10;
    g = model_pick(req_val);
    @(negedge clk);
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b111;
    @(negedge clk);
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b000;
    req_val = 2'b00;
    spi_send_val = 1'b1;
    resp_rdy = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if ({req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val} !== '0) begin
      errors++;
      $display("FAIL xfer_drop_idle req%0d: got %b want 0", g, {req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val});
    end
    spi_send_val = 1'b0;
    resp_rdy = '0;
    run_txn(2'b11, rand_msg(), rand_msg(), rand_msg(), 0, 0, 0);
  endtask

  task automatic test_mid_reset;
    cfg_write(0, 5, 1, 7);
    req_val = 2'b01;
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b111;
    spi_recv_rdy = 1'b1;
    repeat (3) @(negedge clk);
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b000;
    spi_recv_rdy = 1'b0;
    spi_send_val = 1'b1;
    spi_send_msg = rand_msg();
    resp_rdy = '0;
    #1;
    checks++;
    if (resp_val !== 2'b01) begin
      errors++;
      $display("FAIL midrst_in_resp: got %b want 01", resp_val);
    end
    reset = 1'b1;
    resp_rdy = 2'b11;
    @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val, cfg_rdy} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b want 0", {req_rdy, resp_val, spi_recv_val, spi_send_rdy, spi_packet_size_val, cfg_rdy});
    end
    reset = 1'b0;
    req_val = '0;
    spi_send_val = 1'b0;
    resp_rdy = '0;
    model_reset();
    @(negedge clk);
    run_txn(2'b01, rand_msg(), rand_msg(), rand_msg(), 0, 0, 0);
    run_txn(2'b11, rand_msg(), rand_msg(), rand_msg(), 0, 0, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write($urandom_range(0, NREQ - 1), $urandom_range(1, NBITS), $urandom_range(0, 1), $urandom_range(0, 7));
      run_txn(NREQ'($urandom_range(1, 3)), rand_msg(), rand_msg(), rand_msg(),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_timeout;
`ifdef SPI_ARB_TIMEOUT_EN
    int stalls;
    bit hit;
    int g;
    stalls = 0;
    hit = 1'b0;
    req_val = 2'b01;
    g = model_pick(req_val);
    @(negedge clk);
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b111;
    @(negedge clk);
    {spi_packet_size_rdy, spi_cs_addr_rdy, spi_freq_rdy} = 3'b000;
    spi_recv_rdy = 1'b1;
    @(negedge clk);
    spi_recv_rdy = 1'b0;
    req_val = '0;
    spi_send_val = 1'b1;
    resp_rdy = '0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre_err: got %b want 0", err_timeout);
    end
    for (int c = 0; c < 40 && !hit; c++) begin
      #1;
      if (spi_send_rdy === 1'b1) begin
        hit = 1'b1;
        checks++;
        if (resp_val !== '0) begin
          errors++;
          $display("FAIL timeout_drop: got resp_val=%b want 00", resp_val);
        end
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    checks++;
    if (!hit || stalls != 10) begin
      errors++;
      $display("FAIL timeout_stalls: got hit=%0d stalls=%0d want hit=1 stalls=10", hit, stalls);
    end
    @(negedge clk);
    spi_send_val = 1'b0;
    m_rr = (g + 1) % NREQ;
    #1;
    checks++;
    if (err_timeout !== 1'b1 || spi_send_rdy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got err=%b send_rdy=%b want 1/0", err_timeout, spi_send_rdy);
    end
    run_txn(2'b11, rand_msg(), rand_msg(), rand_msg(), 0, 0, 0);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    req_val = '0;
    req_msg = '0;
    resp_rdy = '0;
    cfg_val = 1'b0;
    cfg_id = '0;
    cfg_packet_size = '0;
    cfg_cs_addr = '0;
    cfg_freq = '0;
    spi_recv_rdy = 1'b0;
    spi_send_val = 1'b0;
    spi_send_msg = '0;
    spi_packet_size_rdy = 1'b0;
    spi_cs_addr_rdy = 1'b0;
    spi_freq_rdy = 1'b0;
    model_reset();
    test_reset();
    test_config_ok();
    test_round_robin();
    test_per_req_config();
    test_backpressure();
    test_xfer_drop();
    test_mid_reset();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
